// File: rtl/crtc_row_dma_if.sv
// Bus-side port of the CRTC row-fetch DMA: arbiter handshake plus the RAM read port.
interface crtc_row_dma_if #(
    parameter int ADR_W = 17
);
    logic             busreq;
    logic             busack;
    logic [ADR_W-1:0] ram_adr;
    logic [7:0]       ram_data;

    modport master (output busreq, output ram_adr, input busack, input ram_data);
    modport slave  (input busreq, input ram_adr, output busack, output ram_data);
endinterface

// File: rtl/crtc_row_dma.sv
// Row-fetch DMA for the text CRTC: bursts one character row from RAM into a double-buffered
// row buffer. Optional underrun statistics counter is built when CRTC_DMA_STATS_EN is defined.
module crtc_row_dma #(
    parameter int               COLS      = 80,
    parameter int               ATR_PAIRS = 20,
    parameter int               ADR_W     = 17,
    parameter logic [ADR_W-1:0] SRC_BASE  = 17'h0F300,
    parameter int               BUF_AW    = 7,
    parameter int               REL_DELAY = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_en_i,
    input  logic              frame_start_i,
    input  logic              row_start_i,
    input  logic              row_swap_i,
    crtc_row_dma_if.master    bus,
    input  logic [BUF_AW-1:0] rd_adr_i,
    output logic [7:0]        rd_data_o,
    output logic              busy_o,
    output logic              row_ready_o,
    output logic              underrun_o,
    output logic [7:0]        underrun_cnt_o
);
    localparam int NBYTES = COLS + 2 * ATR_PAIRS;
    localparam int CNT_W  = (REL_DELAY > 1) ? $clog2(REL_DELAY) : 1;
    localparam logic [BUF_AW-1:0] LAST_IDX = BUF_AW'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(REL_DELAY - 1);

    if (NBYTES > (1 << BUF_AW)) begin : g_size_chk
        $error("crtc_row_dma: row of %0d bytes does not fit a %0d-byte bank", NBYTES, 1 << BUF_AW);
    end
    if (REL_DELAY < 1) begin : g_delay_chk
        $error("crtc_row_dma: REL_DELAY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, READ, HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADR_W-1:0]  src_q, src_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [BUF_AW-1:0] idx_q, idx_d;
    logic [BUF_AW-1:0] wr_idx_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              reload_q, reload_d;
    logic              wr_pend_q, wr_pend_d;
    logic              last_pend_q, last_pend_d;
    logic              row_ready_q, row_ready_d;
    logic              front_q, front_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        rd_data_q;
    logic              ack;
    logic              issue;
    logic              fetch_start;
    logic [7:0]        mem [0:(1 << (BUF_AW + 1)) - 1];

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        adr_d       = adr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q | frame_start_i;
        wr_pend_d   = 1'b0;
        last_pend_d = 1'b0;
        row_ready_d = row_ready_q;
        front_d     = front_q;
        underrun_d  = underrun_q;
        ack         = bus.busack & dma_en_i;
        issue       = 1'b0;
        fetch_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (row_start_i && dma_en_i) begin
                    // A frame reload (pending or same-cycle) is consumed by this row.
                    fetch_start = 1'b1;
                    state_d     = REQ;
                    idx_d       = '0;
                    src_d       = (frame_start_i || reload_q) ? SRC_BASE : src_q;
                    adr_d       = (frame_start_i || reload_q) ? SRC_BASE : src_q;
                    reload_d    = 1'b0;
                end
            end
            REQ: begin
                if (ack) state_d = READ;
            end
            READ: begin
                if (ack) begin
                    issue     = 1'b1;
                    wr_pend_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d     = HOLD;
                        cnt_d       = '0;
                        last_pend_d = 1'b1;
                        src_d       = adr_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        adr_d = adr_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == LAST_CNT) state_d = IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Row becomes visible the cycle after its last byte lands, unless the fetch was dropped.
        if (last_pend_q && dma_en_i) row_ready_d = 1'b1;

        if (row_swap_i) begin
            if (row_ready_q) begin
                front_d     = ~front_q;
                row_ready_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
        end

        if (fetch_start) row_ready_d = 1'b0;

        if (!dma_en_i && state_q != IDLE) begin
            state_d     = IDLE;
            last_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= SRC_BASE;
            adr_q       <= SRC_BASE;
            idx_q       <= '0;
            cnt_q       <= '0;
            reload_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            last_pend_q <= 1'b0;
            row_ready_q <= 1'b0;
            front_q     <= 1'b0;
            underrun_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            adr_q       <= adr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            wr_pend_q   <= wr_pend_d;
            last_pend_q <= last_pend_d;
            row_ready_q <= row_ready_d;
            front_q     <= front_d;
            underrun_q  <= underrun_d;
            rd_data_q   <= mem[{front_q, rd_adr_i}];
        end
    end

    // RAM data arrives one cycle after its address; the write trails the issue by one cycle.
    always_ff @(posedge clk) begin
        if (wr_pend_q) mem[{~front_q, wr_idx_q}] <= bus.ram_data;
        if (issue)     wr_idx_q <= idx_q;
    end

`ifdef CRTC_DMA_STATS_EN
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (row_swap_i && !row_ready_q && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ucnt_q <= '0;
        else       ucnt_q <= ucnt_d;
    end

    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = 8'h00;
`endif

    assign bus.busreq  = (state_q == REQ || state_q == READ) && dma_en_i;
    assign bus.ram_adr = adr_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q != IDLE);
    assign row_ready_o = row_ready_q;
    assign underrun_o  = underrun_q;
endmodule

// File: tb/tb_crtc_row_dma.sv
// Directed bench for crtc_row_dma: a default-size instance and a 12-bit wrapping instance.
`timescale 1ns/1ps
module tb_crtc_row_dma;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   vec = 0;
    int   bad = 0;
    int   cyc = 0;

`ifdef CRTC_DMA_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       en0, fs0, rs0, sw0, busy0, rdy0, ur0;
    logic [6:0] ra0;
    logic [7:0] rd0, uc0;
    logic       en1, fs1, rs1, sw1, busy1, rdy1, ur1;
    logic [6:0] ra1;
    logic [7:0] rd1, uc1;

    crtc_row_dma_if #(.ADR_W(17)) b0 ();
    crtc_row_dma_if #(.ADR_W(12)) b1 ();

    crtc_row_dma u0 (
        .clk(clk), .reset(reset), .dma_en_i(en0), .frame_start_i(fs0), .row_start_i(rs0),
        .row_swap_i(sw0), .bus(b0), .rd_adr_i(ra0), .rd_data_o(rd0), .busy_o(busy0),
        .row_ready_o(rdy0), .underrun_o(ur0), .underrun_cnt_o(uc0));

    crtc_row_dma #(.ADR_W(12), .SRC_BASE(12'hFC0), .REL_DELAY(4)) u1 (
        .clk(clk), .reset(reset), .dma_en_i(en1), .frame_start_i(fs1), .row_start_i(rs1),
        .row_swap_i(sw1), .bus(b1), .rd_adr_i(ra1), .rd_data_o(rd1), .busy_o(busy1),
        .row_ready_o(rdy1), .underrun_o(ur1), .underrun_cnt_o(uc1));

    function automatic logic [7:0] rv(input logic [16:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ {7'd0, a[16]} ^ 8'h3C;
    endfunction

    // RAM models: data valid one cycle after the address.
    always @(posedge clk) b0.ram_data <= rv(b0.ram_adr);
    always @(posedge clk) b1.ram_data <= rv({5'd0, b1.ram_adr});
    always @(posedge clk) cyc <= cyc + 1;

    // Acked addresses; the first ack of each request is the grant, not a read.
    logic [16:0] aq0[$];
    int          cq0[$];
    logic [11:0] aq1[$];
    bit          g0 = 1'b0, g1 = 1'b0;

    always @(negedge clk) begin
        if (reset || !b0.busreq) g0 <= 1'b0;
        else if (b0.busack) begin
            if (g0) begin aq0.push_back(b0.ram_adr); cq0.push_back(cyc); end
            g0 <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset || !b1.busreq) g1 <= 1'b0;
        else if (b1.busack) begin
            if (g1) aq1.push_back(b1.ram_adr);
            g1 <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run0(input int lim);
        int n = 0;
        while (aq0.size() < 120 && n < lim) begin step(); n++; end
        while (busy0 && n < lim) begin step(); n++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en0 = 0; fs0 = 0; rs0 = 0; sw0 = 0; ra0 = '0; b0.busack = 1'b0;
        en1 = 0; fs1 = 0; rs1 = 0; sw1 = 0; ra1 = '0; b1.busack = 1'b0;
        step(); step();
        reset = 1'b0;
        vec++; if (b0.busreq !== 1'b0) begin bad++; $display("FAIL rst_busreq: got %b want 0", b0.busreq); end
        vec++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy0); end
        vec++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL rst_row_ready: got %b want 0", rdy0); end
        vec++; if (ur0 !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", ur0); end
        vec++; if (uc0 !== 8'h00) begin bad++; $display("FAIL rst_ucnt: got %h want 00", uc0); end
        vec++; if (b0.ram_adr !== 17'h0F300) begin bad++; $display("FAIL rst_ram_adr: got %h want 0f300", b0.ram_adr); end
        vec++; if (rd0 !== 8'h00) begin bad++; $display("FAIL rst_rd_data: got %h want 00", rd0); end
        vec++; if (b1.ram_adr !== 12'hFC0) begin bad++; $display("FAIL rst_ram_adr1: got %h want fc0", b1.ram_adr); end
    endtask

    task automatic test_row_fetch();
        int n = 0, hold = 0, errs = 0;
        en0 = 1; b0.busack = 1'b1; aq0.delete(); cq0.delete();
        fs0 = 1; step(); fs0 = 0;
        rs0 = 1; step(); rs0 = 0;
        vec++; if (b0.busreq !== 1'b1) begin bad++; $display("FAIL req_busreq: got %b want 1", b0.busreq); end
        while (aq0.size() < 120 && n < 400) begin step(); n++; end
        vec++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL hold1_row_ready: got %b want 0", rdy0); end
        for (int k = 0; k < aq0.size(); k++)
            if (aq0[k] !== 17'h0F300 + 17'(k) || cq0[k] != cq0[0] + k) errs++;
        vec++; if (errs != 0) begin bad++; $display("FAIL burst_addr_seq: got %0d bad entries want 0", errs); end
        n = 0;
        while (busy0 && n < 3000) begin if (!b0.busreq) hold++; step(); n++; end
        vec++; if (hold != 1500) begin bad++; $display("FAIL release_delay: got %0d want 1500", hold); end
        vec++; if (aq0.size() != 120) begin bad++; $display("FAIL burst_len: got %0d want 120", aq0.size()); end
        vec++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL row_ready: got %b want 1", rdy0); end
    endtask

    task automatic test_src_advance();
        aq0.delete(); cq0.delete();
        rs0 = 1; step(); rs0 = 0;
        run0(3000);
        vec++; if (aq0.size() != 120) begin bad++; $display("FAIL adv_len: got %0d want 120", aq0.size()); end
        vec++; if (aq0.size() == 0 || aq0[0] !== 17'h0F378) begin bad++; $display("FAIL src_advance: got %h want 0f378", aq0.size() ? aq0[0] : 17'h0); end
        vec++; if (busy0 !== 1'b0) begin bad++; $display("FAIL adv_idle: got %b want 0", busy0); end
    endtask

    task automatic test_ack_toggle();
        int n = 0, errs = 0;
        aq0.delete(); cq0.delete(); b0.busack = 1'b0;
        fs0 = 1; rs0 = 1; step(); fs0 = 0; rs0 = 0;
        while (aq0.size() < 120 && n < 600) begin b0.busack = ~b0.busack; step(); n++; end
        b0.busack = 1'b1;
        n = 0;
        while (busy0 && n < 2000) begin step(); n++; end
        vec++; if (aq0.size() != 120) begin bad++; $display("FAIL toggle_len: got %0d want 120", aq0.size()); end
        for (int k = 0; k < aq0.size(); k++) if (aq0[k] !== 17'h0F300 + 17'(k)) errs++;
        vec++; if (errs != 0) begin bad++; $display("FAIL toggle_addr_seq: got %0d bad entries want 0", errs); end
        vec++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL toggle_row_ready: got %b want 1", rdy0); end
        sw0 = 1; step(); sw0 = 0;
        vec++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL swap_clears_ready: got %b want 0", rdy0); end
        errs = 0;
        for (int k = 0; k < 120; k++) begin
            ra0 = 7'(k); step();
            if (rd0 !== rv(17'h0F300 + 17'(k))) errs++;
        end
        vec++; if (errs != 0) begin bad++; $display("FAIL bank_contents: got %0d bad bytes want 0", errs); end
    endtask

    task automatic test_swap_underrun();
        ra0 = 7'd0; step();
        ra0 = 7'd5; step();
        vec++; if (rd0 !== rv(17'h0F305)) begin bad++; $display("FAIL rd_latency: got %h want %h", rd0, rv(17'h0F305)); end
        vec++; if (ur0 !== 1'b0) begin bad++; $display("FAIL pre_underrun: got %b want 0", ur0); end
        sw0 = 1; step(); sw0 = 0;
        ra0 = 7'd0; step(); ra0 = 7'd5; step();
        vec++; if (ur0 !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", ur0); end
        vec++; if (rd0 !== rv(17'h0F305)) begin bad++; $display("FAIL front_unchanged: got %h want %h", rd0, rv(17'h0F305)); end
        vec++; if (uc0 !== (STATS ? 8'h01 : 8'h00)) begin bad++; $display("FAIL ucnt_one: got %h want %h", uc0, STATS ? 8'h01 : 8'h00); end
    endtask

    task automatic test_abort();
        int n = 0, sz;
        aq0.delete(); b0.busack = 1'b1;
        fs0 = 1; rs0 = 1; step(); fs0 = 0; rs0 = 0;
        while (aq0.size() < 40 && n < 200) begin step(); n++; end
        en0 = 0; step();
        vec++; if (b0.busreq !== 1'b0) begin bad++; $display("FAIL abort_busreq: got %b want 0", b0.busreq); end
        vec++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", busy0); end
        vec++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL abort_row_ready: got %b want 0", rdy0); end
        sz = aq0.size(); step(); step();
        vec++; if (sz != 40 || aq0.size() != 40) begin bad++; $display("FAIL abort_len: got %0d want 40", aq0.size()); end
        en0 = 1; aq0.delete();
        rs0 = 1; step(); rs0 = 0;
        run0(3000);
        vec++; if (aq0.size() != 120 || aq0[0] !== 17'h0F300) begin bad++; $display("FAIL refetch: got %0d/%h want 120/0f300", aq0.size(), aq0.size() ? aq0[0] : 17'h0); end
        vec++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL refetch_ready: got %b want 1", rdy0); end
    endtask

    task automatic test_wrap();
        int n = 0, errs = 0;
        en1 = 1; b1.busack = 1'b1; aq1.delete();
        fs1 = 1; step(); fs1 = 0;
        rs1 = 1; step(); rs1 = 0;
        while (aq1.size() < 120 && n < 400) begin step(); n++; end
        vec++; if (rdy1 !== 1'b0 || ur1 !== 1'b0) begin bad++; $display("FAIL wrap_hold1: got rdy=%b ur=%b want 0/0", rdy1, ur1); end
        sw1 = 1; step(); sw1 = 0;
        vec++; if (ur1 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL swap_on_ready_edge: got ur=%b rdy=%b want 1/1", ur1, rdy1); end
        for (int k = 0; k < aq1.size(); k++) if (aq1[k] !== 12'hFC0 + 12'(k)) errs++;
        vec++; if (aq1.size() != 120 || errs != 0) begin bad++; $display("FAIL wrap_seq: got %0d entries %0d bad want 120/0", aq1.size(), errs); end
        vec++; if (aq1.size() != 120 || aq1[63] !== 12'hFFF || aq1[64] !== 12'h000) begin bad++; $display("FAIL wrap_point: got %h,%h want fff,000", aq1[63], aq1[64]); end
        n = 0;
        while (busy1 && n < 50) begin step(); n++; end
        sw1 = 1; step(); sw1 = 0;
        ra1 = 7'd63; step();
        vec++; if (rd1 !== rv(17'h00FFF)) begin bad++; $display("FAIL wrap_data_fff: got %h want %h", rd1, rv(17'h00FFF)); end
        ra1 = 7'd64; step();
        vec++; if (rd1 !== rv(17'h00000)) begin bad++; $display("FAIL wrap_data_000: got %h want %h", rd1, rv(17'h00000)); end
        aq1.delete();
        rs1 = 1; step(); rs1 = 0;
        n = 0;
        while ((aq1.size() < 120 || busy1) && n < 400) begin step(); n++; end
        vec++; if (aq1.size() == 0 || aq1[0] !== 12'h038) begin bad++; $display("FAIL wrap_src: got %h want 038", aq1.size() ? aq1[0] : 12'h0); end
    endtask

    task automatic test_stats();
        sw1 = 1; step(); sw1 = 0;
        vec++; if (rdy1 !== 1'b0 || uc1 !== (STATS ? 8'h01 : 8'h00)) begin bad++; $display("FAIL stats_consume: got rdy=%b cnt=%h want 0/%h", rdy1, uc1, STATS ? 8'h01 : 8'h00); end
        for (int i = 0; i < 253; i++) begin sw1 = 1; step(); sw1 = 0; step(); end
        vec++; if (uc1 !== (STATS ? 8'hFE : 8'h00)) begin bad++; $display("FAIL stats_254: got %h want %h", uc1, STATS ? 8'hFE : 8'h00); end
        sw1 = 1; step(); sw1 = 0; step();
        vec++; if (uc1 !== (STATS ? 8'hFF : 8'h00)) begin bad++; $display("FAIL stats_255: got %h want %h", uc1, STATS ? 8'hFF : 8'h00); end
        for (int i = 0; i < 45; i++) begin sw1 = 1; step(); sw1 = 0; step(); end
        vec++; if (uc1 !== (STATS ? 8'hFF : 8'h00)) begin bad++; $display("FAIL stats_sat: got %h want %h", uc1, STATS ? 8'hFF : 8'h00); end
        ra1 = 7'd64; step();
        vec++; if (rd1 !== rv(17'h00078) || ur1 !== 1'b1) begin bad++; $display("FAIL stats_front: got %h ur=%b want %h/1", rd1, ur1, rv(17'h00078)); end
    endtask

    task automatic test_reset_mid();
        int n = 0, sz;
        aq0.delete(); b0.busack = 1'b1;
        rs0 = 1; step(); rs0 = 0;
        while (aq0.size() < 10 && n < 100) begin step(); n++; end
        reset = 1; step(); reset = 0;
        vec++; if (b0.busreq !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL midrst_drop: got req=%b busy=%b want 0/0", b0.busreq, busy0); end
        vec++; if (b0.ram_adr !== 17'h0F300 || rdy0 !== 1'b0 || ur0 !== 1'b0) begin bad++; $display("FAIL midrst_state: got adr=%h rdy=%b ur=%b want 0f300/0/0", b0.ram_adr, rdy0, ur0); end
        sz = aq0.size(); step(); step(); step();
        vec++; if (aq0.size() != sz) begin bad++; $display("FAIL midrst_no_issue: got %0d want %0d", aq0.size(), sz); end
    endtask

    initial begin
        test_reset();
        test_row_fetch();
        test_src_advance();
        test_ack_toggle();
        test_swap_underrun();
        test_abort();
        test_wrap();
        test_stats();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end
endmodule
